// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch stage. Single-outstanding req/ack reads into
//               a valid/ready hand-off to decode, with redirect and halt.
//               Optional macro FETCH_STATS_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               program_halted,
`ifdef FETCH_STATS_EN
   output logic [31:0]        fetch_count,
   output logic [31:0]        stall_count,
`endif
   output logic               fetch_stopped,
   output logic [ADDR_W-1:0]  pc
);

   localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_STOP} state_t;

   state_t               state_q;
   logic [ADDR_W-1:0]    pc_q;
   logic                 imem_req_q;
   logic [ADDR_W-1:0]    imem_addr_q;
   logic                 instr_valid_q;
   logic [INSTR_W-1:0]   instr_q;
   logic [ADDR_W-1:0]    instr_pc_q;
   logic                 fetch_stopped_q;
   logic                 squash_q;
   logic                 halt_pend_q;

   logic                 w_halt;
   logic [ADDR_W-1:0]    w_target;

   assign w_halt   = program_halted | halt_pend_q;
   assign w_target = redirect_valid ? redirect_pc : pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         pc_q            <= RESET_PC;
         imem_req_q      <= 1'b0;
         imem_addr_q     <= RESET_PC;
         instr_valid_q   <= 1'b0;
         instr_q         <= '0;
         instr_pc_q      <= '0;
         fetch_stopped_q <= 1'b0;
         squash_q        <= 1'b0;
         halt_pend_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (program_halted) begin
                  state_q         <= S_STOP;
                  instr_valid_q   <= 1'b0;
                  fetch_stopped_q <= 1'b1;
               end else begin
                  if (redirect_valid) pc_q <= redirect_pc;
                  if (start) begin
                     state_q     <= S_REQ;
                     imem_req_q  <= 1'b1;
                     imem_addr_q <= w_target;
                  end
               end
            end
            S_REQ: begin
               if (imem_ack) begin
                  if (w_halt) begin
                     // The read has completed, so stopping here never abandons a bus cycle.
                     state_q         <= S_STOP;
                     imem_req_q      <= 1'b0;
                     squash_q        <= 1'b0;
                     halt_pend_q     <= 1'b0;
                     fetch_stopped_q <= 1'b1;
                  end else if (squash_q || redirect_valid) begin
                     squash_q    <= 1'b0;
                     pc_q        <= w_target;
                     imem_addr_q <= w_target;
                  end else begin
                     state_q       <= S_HOLD;
                     imem_req_q    <= 1'b0;
                     instr_q       <= imem_rdata;
                     instr_pc_q    <= imem_addr_q;
                     instr_valid_q <= 1'b1;
                     pc_q          <= pc_q + C_PC_STEP;
                  end
               end else if (w_halt) begin
                  halt_pend_q <= 1'b1;
               end else if (redirect_valid) begin
                  pc_q     <= redirect_pc;
                  squash_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (program_halted) begin
                  state_q         <= S_STOP;
                  instr_valid_q   <= 1'b0;
                  fetch_stopped_q <= 1'b1;
               end else if (redirect_valid) begin
                  state_q       <= S_REQ;
                  pc_q          <= redirect_pc;
                  instr_valid_q <= 1'b0;
                  imem_req_q    <= 1'b1;
                  imem_addr_q   <= redirect_pc;
               end else if (instr_ready) begin
                  state_q       <= S_REQ;
                  instr_valid_q <= 1'b0;
                  imem_req_q    <= 1'b1;
                  imem_addr_q   <= pc_q;
               end
            end
            S_STOP: begin
               imem_req_q      <= 1'b0;
               instr_valid_q   <= 1'b0;
               fetch_stopped_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_q;
   logic [31:0] stall_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else if (state_q != S_STOP) begin
         if (instr_valid_q && instr_ready && (fetch_count_q != 32'hFFFF_FFFF))
            fetch_count_q <= fetch_count_q + 32'd1;
         if ((state_q == S_REQ) && !imem_ack && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

   assign imem_req      = imem_req_q;
   assign imem_addr     = imem_addr_q;
   assign instr_valid   = instr_valid_q;
   assign instr         = instr_q;
   assign instr_pc      = instr_pc_q;
   assign fetch_stopped = fetch_stopped_q;
   assign pc            = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer; a second instance uses
//               RESET_PC=16'hFFFF for the PC wrap case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   typedef struct packed {
      logic [15:0] ins;
      logic [15:0] addr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        instr_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        program_halted;

   logic        imem_req,    d2_imem_req;
   logic [15:0] imem_addr,   d2_imem_addr;
   logic        instr_valid, d2_instr_valid;
   logic [15:0] instr,       d2_instr;
   logic [15:0] instr_pc,    d2_instr_pc;
   logic        fetch_stopped, d2_fetch_stopped;
   logic [15:0] pc,          d2_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, stall_count, d2_fetch_count, d2_stall_count;
`endif

   exp_t sb[$];
   int   checks;
   int   errors;

   fetch_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .program_halted(program_halted),
`ifdef FETCH_STATS_EN
      .fetch_count(fetch_count), .stall_count(stall_count),
`endif
      .fetch_stopped(fetch_stopped), .pc(pc)
   );

   fetch_sequencer #(.RESET_PC(16'hFFFF)) u_dut2 (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(d2_instr_valid), .instr(d2_instr), .instr_pc(d2_instr_pc), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .program_halted(program_halted),
`ifdef FETCH_STATS_EN
      .fetch_count(d2_fetch_count), .stall_count(d2_stall_count),
`endif
      .fetch_stopped(d2_fetch_stopped), .pc(d2_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a presented word, compares it to the scoreboard head, then accepts it.
   task automatic consume();
      int   n = 0;
      exp_t e;
      while (!instr_valid && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("FAIL consume_timeout: instr_valid=%b required 1", instr_valid);
      end else begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got instr=%h pc=%h, required none", instr, instr_pc);
         end else begin
            e = sb.pop_front();
            if (instr !== e.ins || instr_pc !== e.addr) begin
               errors++;
               $display("FAIL word_match: got instr=%h pc=%h, required instr=%h pc=%h",
                        instr, instr_pc, e.ins, e.addr);
            end
         end
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_stopped, pc} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h ipc=%h stop=%b pc=%h, required all zero",
                  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_stopped, pc);
      end
      checks++;
      if (d2_pc !== 16'hFFFF || d2_imem_addr !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_pc_param: pc=%h addr=%h required FFFF", d2_pc, d2_imem_addr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_and_hold();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h required 1/0000", imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 16'h1234;
      sb.push_back('{16'h1234, 16'h0000});
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0000 || pc !== 16'h0001) begin
         errors++;
         $display("FAIL first_fetch: v=%b instr=%h ipc=%h pc=%h required 1/1234/0000/0001",
                  instr_valid, instr, instr_pc, pc);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (instr !== 16'h1234 || instr_pc !== 16'h0000 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: v=%b instr=%h ipc=%h req=%b required 1/1234/0000/0",
                     instr_valid, instr, instr_pc, imem_req);
         end
      end
      consume();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL next_req: req=%b addr=%h v=%b required 1/0001/0", imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_redirect_hold();
      imem_ack = 1'b1; imem_rdata = 16'h5555;   // discarded by the redirect below, never pushed
      tick();
      imem_ack = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b1;
      tick();
      redirect_valid = 1'b0; instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
         errors++;
         $display("FAIL redirect_hold: v=%b req=%b addr=%h required 0/1/0040", instr_valid, imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 16'h4040;
      sb.push_back('{16'h4040, 16'h0040});
      tick();
      imem_ack = 1'b0;
      consume();
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1'b1; redirect_pc = 16'h0080;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 16'h0041) begin
            errors++;
            $display("FAIL req_hold_addr: req=%b addr=%h required 1/0041", imem_req, imem_addr);
         end
         if (i == 0) tick();
      end
      imem_ack = 1'b1; imem_rdata = 16'hBEEF;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
         errors++;
         $display("FAIL squash: v=%b req=%b addr=%h required 0/1/0080", instr_valid, imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 16'h8080;
      sb.push_back('{16'h8080, 16'h0080});
      tick();
      imem_ack = 1'b0;
      consume();
   endtask

   task automatic test_halt();
      program_halted = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b1 || fetch_stopped !== 1'b0) begin
         errors++;
         $display("FAIL halt_wait_ack: req=%b stop=%b required 1/0", imem_req, fetch_stopped);
      end
      tick();
      tick();
      imem_ack = 1'b1; imem_rdata = 16'hDEAD;
      tick();
      imem_ack = 1'b0;
      start = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
      tick();
      tick();
      checks++;
      if (fetch_stopped !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0081) begin
         errors++;
         $display("FAIL stop_state: stop=%b req=%b v=%b pc=%h required 1/0/0/0081",
                  fetch_stopped, imem_req, instr_valid, pc);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (fetch_stopped !== 1'b0) begin
         errors++;
         $display("FAIL rst_clears_stop: stop=%b required 0", fetch_stopped);
      end
      start = 1'b0; redirect_valid = 1'b0; program_halted = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_wrap_and_async_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      imem_ack = 1'b1; imem_rdata = 16'h7777;
      sb.push_back('{16'h7777, 16'h0000});
      tick();
      imem_ack = 1'b0;
      checks++;
      if (d2_instr_pc !== 16'hFFFF || d2_pc !== 16'h0000 || d2_instr !== 16'h7777) begin
         errors++;
         $display("FAIL pc_wrap: ipc=%h pc=%h instr=%h required FFFF/0000/7777", d2_instr_pc, d2_pc, d2_instr);
      end
      consume();
      checks++;
      if (d2_imem_req !== 1'b1 || d2_imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_req: req=%b addr=%h required 1/0000", d2_imem_req, d2_imem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || d2_imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: req=%b req2=%b v=%b required 0/0/0", imem_req, d2_imem_req, instr_valid);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      logic [15:0] d;
      a = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== a) begin
            errors++;
            $display("FAIL b2b_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, a);
         end
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
         d = (a * 16'd3) ^ 16'h5A5A;
         imem_ack = 1'b1; imem_rdata = d;
         sb.push_back('{d, a});
         tick();
         imem_ack = 1'b0;
         a = a + 16'd1;
         checks++;
         if (pc !== a) begin
            errors++;
            $display("FAIL b2b_pc: pc=%h required %h", pc, a);
         end
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
         consume();
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d words left, required 0", sb.size());
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; program_halted = 1'b0;
      test_reset();
      test_basic_and_hold();
      test_redirect_hold();
      test_redirect_req();
      test_halt();
      test_wrap_and_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch stage feeding decode, which in turn drives the halt block. Holds the program counter and issues one instruction-memory read at a time over a req/ack handshake. Presents each fetched word to decode over a valid/ready handshake and accepts branch redirects. Consumes program_halted from the halt block and stops all fetching permanently, until reset, once it is set.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded at reset
PC_STEP, 1, PC increment per fetched instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin fetching from the current PC; only honoured in IDLE
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  read address; stable while imem_req=1
imem_ack  in  1  read data valid this cycle; ignored when imem_req=0
imem_rdata  in  INSTR_W  read data
instr_valid  out  1  fetched instruction available to decode
instr  out  INSTR_W  fetched instruction
instr_pc  out  ADDR_W  address of instr
instr_ready  in  1  decode accepts instr
redirect_valid  in  1  load PC with redirect_pc
redirect_pc  in  ADDR_W  branch/jump target
program_halted  in  1  from halt block; sticky stop request
fetch_stopped  out  1  high while in STOP
pc  out  ADDR_W  next address to fetch

Behaviour:
- Reset, asynchronous: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_stopped=0, squash=0. All outputs are registered.
- IDLE: start=1 -> imem_req=1, imem_addr=pc next cycle; state REQ.
- REQ: imem_req and imem_addr are held until imem_ack.
  - On ack with squash=0: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+PC_STEP modulo 2^ADDR_W, imem_req<=0; state HOLD.
  - On ack with squash=1: data is dropped, squash<=0, and a new request goes out at pc the next cycle.
  - Memory latency is unbounded.
- HOLD: instr, instr_pc and instr_valid are held stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0, imem_req<=1, imem_addr<=pc; state REQ.
  - Throughput is at most one instruction per 2 cycles with zero-wait memory.
- Redirect:
  - IDLE: pc<=redirect_pc, state unchanged.
  - HOLD: pc<=redirect_pc, instr_valid<=0 (held word discarded even if instr_ready=1 the same cycle), request at redirect_pc next cycle.
  - REQ: an outstanding request is never aborted; pc<=redirect_pc, squash<=1, and the in-flight data is discarded on ack. Redirect on the ack cycle behaves the same: data is discarded and the next request goes out at redirect_pc.
  - STOP: ignored.
- Halt (sampled every cycle; beats redirect and start in the same cycle):
  - IDLE/HOLD: instr_valid<=0; state STOP.
  - REQ: wait for imem_ack, discard the data; state STOP.
- STOP: imem_req=0, instr_valid=0, fetch_stopped=1. Only rst exits STOP; start is ignored.
- Reset mid-handshake drops imem_req and instr_valid immediately.

Optional Feature:
FETCH_STATS_EN defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
- fetch_count increments on each instr_valid&&instr_ready.
- stall_count increments on each REQ cycle with imem_ack=0.
- Both saturate at 0xFFFFFFFF and freeze in STOP.
Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset with defaults, start, ack one cycle later with rdata=0x1234 -> imem_addr=0x0000, then instr=0x1234, instr_pc=0x0000, instr_valid=1, pc=0x0001.
2. Hold instr_ready=0 for 3 cycles in HOLD -> instr and instr_pc unchanged, imem_req stays 0; ready=1 -> next cycle imem_req=1 with imem_addr=0x0001.
3. redirect_valid with redirect_pc=0x0040 in HOLD -> instr_valid=0 next cycle, next request at imem_addr=0x0040, later instr_pc=0x0040.
4. Redirect to 0x0080 in REQ, ack 2 cycles later with 0xBEEF -> imem_addr stays at the old value until ack, 0xBEEF never presented, next request at 0x0080.
5. program_halted=1 in REQ, ack 3 cycles later -> data dropped, fetch_stopped=1, imem_req remains 0 despite start=1 and redirect_valid=1; rst clears fetch_stopped.
6. RESET_PC=0xFFFF: fetch one word -> pc wraps to 0x0000. Assert rst mid-REQ -> imem_req=0 before the next clock edge.
